// File: rtl/alveo_u50_rst_seq_if.sv
// Signal bundle for the Alveo U50 reset sequencer.
// The slave modport is the sequencer's view; the master modport is the environment's view.
interface alveo_u50_rst_seq_if;
  logic       idelay_rdy;
  logic       soft_rst_req;
  logic       rst_core;
  logic       rst_periph;
  logic       rst_user;
  logic       seq_done;
  logic       timeout_err;
  logic [7:0] rdy_loss_cnt;
  logic [2:0] seq_state;
  logic       heartbeat;

  modport slave (
    input  idelay_rdy,
    input  soft_rst_req,
    output rst_core,
    output rst_periph,
    output rst_user,
    output seq_done,
    output timeout_err,
    output rdy_loss_cnt,
    output seq_state,
    output heartbeat
  );

  modport master (
    output idelay_rdy,
    output soft_rst_req,
    input  rst_core,
    input  rst_periph,
    input  rst_user,
    input  seq_done,
    input  timeout_err,
    input  rdy_loss_cnt,
    input  seq_state,
    input  heartbeat
  );
endinterface

// File: rtl/alveo_u50_rst_seq.sv
// Staged reset release sequencer: waits for IDELAYCTRL ready, then releases core, peripheral
// and user resets in turn, each held STAGE_DLY cycles. Loss of ready or a software request
// restarts the sequence; a ready timeout parks the sequencer in an error state.
// Optional feature: define RST_SEQ_HEARTBEAT_EN for a heartbeat toggle while running.
module alveo_u50_rst_seq #(
  parameter int unsigned STAGE_DLY   = 1024,
  parameter int unsigned RDY_TIMEOUT = 2000000
) (
  input logic                sys_clk,
  input logic                sys_rst,
  alveo_u50_rst_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitRdy   = 3'd1,
    StRelCore   = 3'd2,
    StRelPeriph = 3'd3,
    StRelUser   = 3'd4,
    StRun       = 3'd5,
    StErr       = 3'd6
  } state_e;

  localparam logic [15:0] StageLast = 16'(STAGE_DLY - 1);
  localparam logic [23:0] TmoLast   = 24'(RDY_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        rdy_meta_q, rdy_s;
  logic [15:0] stage_cnt_q, stage_cnt_d;
  logic [23:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]  loss_cnt_q, loss_cnt_d;
  logic        rdy_loss, leave, stage_done, restart;

  // Two-flop synchronizer for the asynchronous IDELAYCTRL ready.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rdy_meta_q <= 1'b0;
      rdy_s      <= 1'b0;
    end else begin
      rdy_meta_q <= bus.idelay_rdy;
      rdy_s      <= rdy_meta_q;
    end
  end

  // Next-state, counter and loss-count logic.
  always_comb begin
    state_d    = state_q;
    rdy_loss   = (state_q inside {StRelCore, StRelPeriph, StRelUser, StRun}) && !rdy_s;
    leave      = rdy_loss || bus.soft_rst_req;
    stage_done = (stage_cnt_q == StageLast);
    case (state_q)
      StIdle: state_d = StWaitRdy;
      StWaitRdy: begin
        // Ready beats the timeout when both land on the same cycle.
        if (bus.soft_rst_req)        state_d = StWaitRdy;
        else if (rdy_s)              state_d = StRelCore;
        else if (tmo_cnt_q == TmoLast) state_d = StErr;
      end
      StRelCore: begin
        if (leave)           state_d = StWaitRdy;
        else if (stage_done) state_d = StRelPeriph;
      end
      StRelPeriph: begin
        if (leave)           state_d = StWaitRdy;
        else if (stage_done) state_d = StRelUser;
      end
      StRelUser: begin
        if (leave)           state_d = StWaitRdy;
        else if (stage_done) state_d = StRun;
      end
      StRun: begin
        if (leave) state_d = StWaitRdy;
      end
      StErr: begin
        // Ready returning is deliberately ignored; only software or sys_rst leaves here.
        if (bus.soft_rst_req) state_d = StWaitRdy;
      end
      default: state_d = StWaitRdy;
    endcase

    // A soft request re-enters WAIT_RDY even from WAIT_RDY, so it also counts as an entry.
    restart     = (state_d != state_q) || bus.soft_rst_req;
    stage_cnt_d = restart ? 16'd0 : stage_cnt_q + 16'd1;
    tmo_cnt_d   = (restart || (state_q != StWaitRdy)) ? 24'd0 : tmo_cnt_q + 24'd1;
    loss_cnt_d  = (rdy_loss && (loss_cnt_q != 8'hFF)) ? loss_cnt_q + 8'd1 : loss_cnt_q;
  end

  // State and counter registers.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= StIdle;
      stage_cnt_q <= 16'd0;
      tmo_cnt_q   <= 24'd0;
      loss_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      stage_cnt_q <= stage_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign bus.rst_core     = (state_q inside {StIdle, StWaitRdy, StErr});
  assign bus.rst_periph   = bus.rst_core || (state_q == StRelCore);
  assign bus.rst_user     = bus.rst_periph || (state_q == StRelPeriph);
  assign bus.seq_done     = (state_q == StRun);
  assign bus.timeout_err  = (state_q == StErr);
  assign bus.rdy_loss_cnt = loss_cnt_q;
  assign bus.seq_state    = state_q;

`ifdef RST_SEQ_HEARTBEAT_EN
  logic [23:0] hb_cnt_q;
  logic        hb_q;

  // Free-running counter in RUN only; heartbeat flips on every wrap.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      hb_cnt_q <= 24'd0;
      hb_q     <= 1'b0;
    end else if (state_q == StRun) begin
      hb_cnt_q <= hb_cnt_q + 24'd1;
      if (hb_cnt_q == 24'hFFFFFF) hb_q <= ~hb_q;
    end else begin
      hb_cnt_q <= 24'd0;
    end
  end

  assign bus.heartbeat = hb_q;
`else
  assign bus.heartbeat = 1'b0;
`endif

endmodule

// File: tb/tb_alveo_u50_rst_seq.sv
// Directed bench for alveo_u50_rst_seq with STAGE_DLY=8, RDY_TIMEOUT=100.
// Expected output snapshots are queued with a due cycle and checked when that cycle arrives.
module tb_alveo_u50_rst_seq;

  logic sys_clk = 1'b0;
  logic sys_rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  alveo_u50_rst_seq_if bus ();

  alveo_u50_rst_seq #(
    .STAGE_DLY  (8),
    .RDY_TIMEOUT(100)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          due;
    string       tag;
    logic [16:0] exp;
    logic [16:0] mask;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [16:0] MaskAll = 17'h1FFFF;

  function automatic logic [16:0] exp_vec(input logic [2:0] st, input logic [7:0] c);
    logic rc, rp, ru;
    rc = (st == 3'd0) || (st == 3'd1) || (st == 3'd6);
    rp = rc || (st == 3'd2);
    ru = rp || (st == 3'd3);
    return {1'b0, rc, rp, ru, (st == 3'd5), (st == 3'd6), st, c};
  endfunction

  function automatic logic [16:0] obs();
    return {bus.heartbeat, bus.rst_core, bus.rst_periph, bus.rst_user, bus.seq_done,
            bus.timeout_err, bus.seq_state, bus.rdy_loss_cnt};
  endfunction

  // Queue an expectation d cycles from now, kept sorted by due cycle.
  task automatic push_exp(input int d, input string tag, input logic [16:0] e,
                          input logic [16:0] m);
    exp_t item;
    int   idx;
    item.due  = cyc + d;
    item.tag  = tag;
    item.exp  = e;
    item.mask = m;
    idx = exp_q.size();
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].due > item.due) begin
        idx = i;
        break;
      end
    end
    exp_q.insert(idx, item);
  endtask

  task automatic exp_st(input int d, input string tag, input logic [2:0] st,
                        input logic [7:0] c);
    push_exp(d, tag, exp_vec(st, c), MaskAll);
  endtask

  // Advance one clock, sample 1 ns after the edge, retire due expectations.
  task automatic step();
    exp_t        item;
    logic [16:0] o;
    @(posedge sys_clk);
    #1;
    cyc++;
    o = obs();
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      item = exp_q.pop_front();
      n_cmp++;
      assert ((o & item.mask) === (item.exp & item.mask))
      else begin
        n_bad++;
        $error("FAIL %s @cyc %0d: observed %h required %h", item.tag, cyc, o & item.mask,
               item.exp & item.mask);
      end
    end
  endtask

  // REL_CORE entered d0 cycles from now; follow the release stages into RUN.
  task automatic seq_from(input int d0, input logic [7:0] c, input string tag);
    exp_st(d0,      {tag, "_core"},       3'd2, c);
    exp_st(d0 + 7,  {tag, "_core_end"},   3'd2, c);
    exp_st(d0 + 8,  {tag, "_periph"},     3'd3, c);
    exp_st(d0 + 15, {tag, "_periph_end"}, 3'd3, c);
    exp_st(d0 + 16, {tag, "_user"},       3'd4, c);
    exp_st(d0 + 23, {tag, "_user_end"},   3'd4, c);
    exp_st(d0 + 24, {tag, "_run"},        3'd5, c);
    repeat (d0 + 24) step();
  endtask

  initial begin
    exp_t item;
    logic [7:0] ec;

    sys_rst          = 1'b1;
    bus.idelay_rdy   = 1'b1;
    bus.soft_rst_req = 1'b0;

    // Reset, then normal boot with ready already high.
    exp_st(1, "reset_first", 3'd0, 8'd0);
    exp_st(4, "reset_hold",  3'd0, 8'd0);
    repeat (4) step();
    sys_rst = 1'b0;
    exp_st(1, "boot_idle_exit", 3'd1, 8'd0);
    exp_st(2, "boot_sync_wait", 3'd1, 8'd0);
    seq_from(3, 8'd0, "boot");
    exp_st(5, "run_hold", 3'd5, 8'd0);
    repeat (5) step();

    // One-cycle ready drop in RUN: WAIT_RDY three edges later, then full re-release.
    bus.idelay_rdy = 1'b0;
    exp_st(1, "drop_run1", 3'd5, 8'd0);
    exp_st(2, "drop_run2", 3'd5, 8'd0);
    exp_st(3, "drop_wait", 3'd1, 8'd1);
    step();
    bus.idelay_rdy = 1'b1;
    seq_from(3, 8'd1, "drop");

    // Soft request in RUN: restart without counting a loss.
    bus.soft_rst_req = 1'b1;
    exp_st(1, "soft_wait", 3'd1, 8'd1);
    step();
    bus.soft_rst_req = 1'b0;
    seq_from(1, 8'd1, "soft");

    // Soft request coinciding with ready loss in REL_PERIPH: one entry, one count.
    bus.soft_rst_req = 1'b1;
    exp_st(1, "combo_pre_wait", 3'd1, 8'd1);
    step();
    bus.soft_rst_req = 1'b0;
    exp_st(1, "combo_pre_core", 3'd2, 8'd1);
    exp_st(9, "combo_pre_periph", 3'd3, 8'd1);
    repeat (9) step();
    bus.idelay_rdy = 1'b0;
    exp_st(1, "combo_periph1", 3'd3, 8'd1);
    exp_st(2, "combo_periph2", 3'd3, 8'd1);
    step();
    bus.idelay_rdy = 1'b1;
    step();
    bus.soft_rst_req = 1'b1;
    exp_st(1, "combo_wait", 3'd1, 8'd2);
    step();
    bus.soft_rst_req = 1'b0;
    seq_from(1, 8'd2, "combo");

    // sys_rst in the middle of REL_USER.
    bus.soft_rst_req = 1'b1;
    exp_st(1, "mid_pre_wait", 3'd1, 8'd2);
    step();
    bus.soft_rst_req = 1'b0;
    exp_st(17, "mid_pre_user", 3'd4, 8'd2);
    repeat (19) step();
    sys_rst = 1'b1;
    exp_st(1, "mid_rst", 3'd0, 8'd0);
    exp_st(2, "mid_rst_hold", 3'd0, 8'd0);
    repeat (2) step();
    sys_rst = 1'b0;
    exp_st(1, "reboot_idle_exit", 3'd1, 8'd0);
    exp_st(2, "reboot_sync_wait", 3'd1, 8'd0);
    seq_from(3, 8'd0, "reboot");

    // 300 ready pulses: loss count saturates at 255.
    for (int i = 0; i < 300; i++) begin
      ec = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
      bus.idelay_rdy = 1'b0;
      exp_st(3, "sat_wait", 3'd1, ec);
      step();
      bus.idelay_rdy = 1'b1;
      repeat (5) step();
    end
    exp_st(6,  "sat_periph", 3'd3, 8'd255);
    exp_st(14, "sat_user",   3'd4, 8'd255);
    exp_st(22, "sat_run",    3'd5, 8'd255);
    repeat (22) step();

    // Ready never arrives: ERR after exactly 100 WAIT_RDY cycles.
    sys_rst        = 1'b1;
    bus.idelay_rdy = 1'b0;
    exp_st(1, "tmo_rst", 3'd0, 8'd0);
    repeat (2) step();
    sys_rst = 1'b0;
    exp_st(1,   "tmo_wait_first", 3'd1, 8'd0);
    exp_st(100, "tmo_wait_last",  3'd1, 8'd0);
    exp_st(101, "tmo_err",        3'd6, 8'd0);
    repeat (101) step();
    bus.idelay_rdy = 1'b1;
    exp_st(10, "err_ignores_rdy", 3'd6, 8'd0);
    repeat (10) step();
    bus.soft_rst_req = 1'b1;
    exp_st(1, "err_clear", 3'd1, 8'd0);
    step();
    bus.soft_rst_req = 1'b0;
    seq_from(1, 8'd0, "recover");

    // Ready seen on the final timeout cycle: REL_CORE wins over ERR.
    sys_rst        = 1'b1;
    bus.idelay_rdy = 1'b0;
    exp_st(1, "tie_rst", 3'd0, 8'd0);
    repeat (2) step();
    sys_rst = 1'b0;
    exp_st(1,   "tie_wait_first", 3'd1, 8'd0);
    exp_st(100, "tie_wait_last",  3'd1, 8'd0);
    repeat (98) step();
    bus.idelay_rdy = 1'b1;
    seq_from(3, 8'd0, "tie");

    // Any expectation still queued was never reached.
    while (exp_q.size() > 0) begin
      item = exp_q.pop_front();
      n_cmp++;
      n_bad++;
      $error("FAIL %s: due cycle %0d never reached, observed none required %h", item.tag,
             item.due, item.exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
